// File: rtl/hack_kbd_ps2_rx.sv
// hack_kbd_ps2_rx
//   Receives PS/2 scan-code set 2 frames and keeps the 16-bit Hack keyboard
//   register (KBD). KBD holds the Hack key code of the key currently held,
//   or 0 when no mapped key is held.
//
//   Ports:
//     clk        system clock
//     reset      synchronous, active-high reset
//     ps2_clk    PS/2 clock line (asynchronous)
//     ps2_data   PS/2 data line (asynchronous)
//     out        KBD register value (Hack key code or 0)
//     key_strobe one-cycle pulse whenever out changes value
//     frame_err  one-cycle pulse on start, parity, stop or timeout error
//
//   Latency: a byte whose stop bit is sampled in cycle N (the cycle in
//   which the synchronised clock is seen falling) lands on out, together
//   with key_strobe, at the second clock edge after that cycle.
module hack_kbd_ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] out,
  output logic        key_strobe,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Set 2 scan code (with pending E0 flag) to Hack key code; 0 = unmapped.
  function automatic logic [15:0] map_code(input logic [7:0] code,
                                           input logic       ext);
    logic [15:0] hack;
    hack = 16'd0;
    if (ext) begin
      case (code)
        8'h6B:   hack = 16'd130;
        8'h75:   hack = 16'd131;
        8'h74:   hack = 16'd132;
        8'h72:   hack = 16'd133;
        default: hack = 16'd0;
      endcase
    end else begin
      case (code)
        8'h1C:   hack = 16'd65;
        8'h32:   hack = 16'd66;
        8'h21:   hack = 16'd67;
        8'h23:   hack = 16'd68;
        8'h24:   hack = 16'd69;
        8'h2B:   hack = 16'd70;
        8'h34:   hack = 16'd71;
        8'h33:   hack = 16'd72;
        8'h43:   hack = 16'd73;
        8'h3B:   hack = 16'd74;
        8'h42:   hack = 16'd75;
        8'h4B:   hack = 16'd76;
        8'h3A:   hack = 16'd77;
        8'h31:   hack = 16'd78;
        8'h44:   hack = 16'd79;
        8'h4D:   hack = 16'd80;
        8'h15:   hack = 16'd81;
        8'h2D:   hack = 16'd82;
        8'h1B:   hack = 16'd83;
        8'h2C:   hack = 16'd84;
        8'h3C:   hack = 16'd85;
        8'h2A:   hack = 16'd86;
        8'h1D:   hack = 16'd87;
        8'h22:   hack = 16'd88;
        8'h35:   hack = 16'd89;
        8'h1A:   hack = 16'd90;
        8'h45:   hack = 16'd48;
        8'h16:   hack = 16'd49;
        8'h1E:   hack = 16'd50;
        8'h26:   hack = 16'd51;
        8'h25:   hack = 16'd52;
        8'h2E:   hack = 16'd53;
        8'h36:   hack = 16'd54;
        8'h3D:   hack = 16'd55;
        8'h3E:   hack = 16'd56;
        8'h46:   hack = 16'd57;
        8'h29:   hack = 16'd32;
        8'h5A:   hack = 16'd128;
        8'h66:   hack = 16'd129;
        8'h76:   hack = 16'd140;
        default: hack = 16'd0;
      endcase
    end
    return hack;
  endfunction

  // ---- stage p0: synchronisers and falling-edge detect ----
  logic clk_s1_p0, clk_s2_p0, clk_d_p0;
  logic dat_s1_p0, dat_s2_p0;
  logic sample_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_p0 <= 1'b0;
      clk_s2_p0 <= 1'b0;
      clk_d_p0  <= 1'b0;
      dat_s1_p0 <= 1'b0;
      dat_s2_p0 <= 1'b0;
    end else begin
      clk_s1_p0 <= ps2_clk;
      clk_s2_p0 <= clk_s1_p0;
      clk_d_p0  <= clk_s2_p0;
      dat_s1_p0 <= ps2_data;
      dat_s2_p0 <= dat_s1_p0;
    end
  end

  // Clearing the synchronisers to 0 cannot fake an edge: an edge needs
  // the delayed copy to be 1 first.
  assign sample_p0 = clk_d_p0 & ~clk_s2_p0;

  // ---- stage p1: frame FSM, produces one validated byte ----
  state_t          state;
  logic [2:0]      bit_cnt;
  logic [TW-1:0]   to_cnt;
  logic            par_ok;
  logic [7:0]      sr_p0;
  logic [7:0]      byte_p1;
  logic            vld_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      to_cnt    <= '0;
      par_ok    <= 1'b0;
      frame_err <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      vld_p1    <= 1'b0;
      // A sample event takes priority over an expiring timeout.
      if (sample_p0) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_s2_p0) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            // Odd parity: data bits plus parity bit hold an odd count of ones.
            par_ok <= ^{sr_p0, dat_s2_p0};
            state  <= STOP;
          end
          STOP: begin
            if (dat_s2_p0 && par_ok) vld_p1    <= 1'b1;
            else                     frame_err <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TO_LAST) begin
          state     <= IDLE;
          frame_err <= 1'b1;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  // Byte datapath: shift register and captured byte carry no reset; the
  // valid flag alone decides whether the byte is used.
  always_ff @(posedge clk) begin
    if (sample_p0 && state == DATA) sr_p0 <= {dat_s2_p0, sr_p0[7:1]};
    if (sample_p0 && state == STOP) byte_p1 <= sr_p0;
  end

  // ---- stage p2: scan-code decoder and KBD register ----
  logic        brk, ext;
  logic [15:0] hack_p1;

  assign hack_p1 = map_code(byte_p1, ext);

  always_ff @(posedge clk) begin
    if (reset) begin
      out        <= 16'd0;
      key_strobe <= 1'b0;
      brk        <= 1'b0;
      ext        <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (vld_p1) begin
        case (byte_p1)
          8'hE0: ext <= 1'b1;
          8'hF0: brk <= 1'b1;
          default: begin
            if (hack_p1 != 16'd0) begin
              if (brk) begin
                // Releasing a key other than the one shown is ignored.
                if (out == hack_p1) begin
                  out        <= 16'd0;
                  key_strobe <= 1'b1;
                end
              end else if (out != hack_p1) begin
                // Typematic repeats of the held key fall through silently.
                out        <= hack_p1;
                key_strobe <= 1'b1;
              end
            end
            brk <= 1'b0;
            ext <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hack_kbd_ps2_rx.sv
// Bench for hack_kbd_ps2_rx: table of frames with expected KBD value and
// pulse counts, hand sequences for latency, timeout and mid-frame reset,
// then random frames against a behavioural keyboard model.
module tb_hack_kbd_ps2_rx;

  localparam int T = 300;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] out;
  logic        key_strobe;
  logic        frame_err;

  hack_kbd_ps2_rx #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out(out), .key_strobe(key_strobe), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_strb = 0;
  int n_err  = 0;

  always @(negedge clk) begin
    if (key_strobe) n_strb++;
    if (frame_err)  n_err++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(HALF / 2);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
    tick(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad);
    logic p;
    p = ~(^code) ^ bad;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(p);
    send_bit(1'b1);
    tick(HALF);
  endtask

  // ---------------- behavioural keyboard model ----------------
  byte unsigned letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned digits[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h36, 8'h3D, 8'h3E, 8'h46};
  byte unsigned arrows[4] = '{8'h6B, 8'h75, 8'h74, 8'h72};

  int  m_out = 0;
  bit  m_ext = 0;
  bit  m_brk = 0;

  function automatic int lookup(input byte unsigned c, input bit e);
    if (e) begin
      foreach (arrows[i]) if (arrows[i] == c) return 130 + i;
      return 0;
    end
    foreach (letters[i]) if (letters[i] == c) return 65 + i;
    foreach (digits[i])  if (digits[i] == c)  return 48 + i;
    if (c == 8'h29) return 32;
    if (c == 8'h5A) return 128;
    if (c == 8'h66) return 129;
    if (c == 8'h76) return 140;
    return 0;
  endfunction

  task automatic model(input byte unsigned c, input bit bad,
                       output int e_strb, output int e_err);
    int h;
    e_strb = 0;
    e_err  = bad ? 1 : 0;
    if (bad) return;
    if (c == 8'hE0) m_ext = 1;
    else if (c == 8'hF0) m_brk = 1;
    else begin
      h = lookup(c, m_ext);
      if (h != 0) begin
        if (m_brk) begin
          if (m_out == h) begin m_out = 0; e_strb = 1; end
        end else if (m_out != h) begin
          m_out = h; e_strb = 1;
        end
      end
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] code;
    bit         bad;
    int         exp_out;
    int         exp_strb;
    int         exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] c, input bit b, input int o,
                     input int s, input int e);
    vec_t v;
    v.code = c; v.bad = b; v.exp_out = o; v.exp_strb = s; v.exp_err = e;
    tbl.push_back(v);
  endtask

  initial begin
    int s0, e0, k, es, ee;
    logic [7:0] c;
    bit b;
    byte unsigned pool[16] = '{8'h1C, 8'h32, 8'h21, 8'h45, 8'h16, 8'h29,
      8'h5A, 8'h66, 8'h76, 8'h6B, 8'h75, 8'h74, 8'h72, 8'h7E, 8'hE0, 8'hF0};

    // A release, then A/B overlap, arrows, bad parity, typematic, keypad 4
    add(8'hF0, 0, 65, 0, 0);  add(8'h1C, 0, 0, 1, 0);
    add(8'h1C, 0, 65, 1, 0);  add(8'h32, 0, 66, 1, 0);
    add(8'hF0, 0, 66, 0, 0);  add(8'h1C, 0, 66, 0, 0);
    add(8'hF0, 0, 66, 0, 0);  add(8'h32, 0, 0, 1, 0);
    add(8'hE0, 0, 0, 0, 0);   add(8'h75, 0, 131, 1, 0);
    add(8'h75, 0, 131, 0, 0);
    add(8'hE0, 0, 131, 0, 0); add(8'hF0, 0, 131, 0, 0);
    add(8'h75, 0, 0, 1, 0);
    add(8'h1C, 1, 0, 0, 1);   add(8'h1C, 0, 65, 1, 0);
    add(8'h1C, 0, 65, 0, 0);  add(8'h6B, 0, 65, 0, 0);
    add(8'hF0, 0, 65, 0, 0);  add(8'h1C, 0, 0, 1, 0);

    tick(4);
    chk("reset_out", out, 0);
    chk("reset_strobe", key_strobe, 0);
    chk("reset_err", frame_err, 0);
    reset = 1'b0;
    tick(4);

    // A make with exact update latency
    s0 = n_strb;
    c = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(c[i]);
    send_bit(~(^c));
    ps2_data = 1'b1;
    tick(HALF / 2);
    ps2_clk = 1'b0;
    tick(3);
    chk("lat_out_before", out, 0);
    tick(1);
    chk("lat_out_after", out, 65);
    chk("lat_strobe", key_strobe, 1);
    tick(1);
    chk("lat_strobe_1cyc", key_strobe, 0);
    tick(HALF - 5);
    ps2_clk = 1'b1;
    tick(HALF / 2 + HALF);
    chk("lat_strobe_count", n_strb - s0, 1);

    foreach (tbl[i]) begin
      s0 = n_strb; e0 = n_err;
      send_frame(tbl[i].code, tbl[i].bad);
      chk($sformatf("tbl%0d_out", i), out, tbl[i].exp_out);
      chk($sformatf("tbl%0d_strb", i), n_strb - s0, tbl[i].exp_strb);
      chk($sformatf("tbl%0d_err", i), n_err - e0, tbl[i].exp_err);
    end

    // Timeout: start + 4 data bits, then silence
    e0 = n_err;
    c = 8'h29;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(c[i]);
    ps2_data = c[3];
    tick(HALF / 2);
    ps2_clk = 1'b0;
    k = 0;
    for (int i = 1; i <= T + 50; i++) begin
      @(negedge clk);
      if (i == HALF) ps2_clk = 1'b1;
      if (frame_err) begin k = i; break; end
    end
    chk("timeout_latency", k, T + 3);
    tick(4);
    chk("timeout_err_count", n_err - e0, 1);
    s0 = n_strb; e0 = n_err;
    send_frame(8'h29, 0);
    chk("after_to_out", out, 32);
    chk("after_to_strb", n_strb - s0, 1);
    chk("after_to_err", n_err - e0, 0);

    // Reset mid-frame between data bits 3 and 4
    send_frame(8'h1C, 0);
    chk("pre_reset_out", out, 65);
    c = 8'h45;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(c[i]);
    reset = 1'b1;
    tick(1);
    chk("midreset_out", out, 0);
    reset = 1'b0;
    s0 = n_strb;
    for (int i = 4; i < 8; i++) send_bit(c[i]);
    send_bit(~(^c));
    send_bit(1'b1);
    tick(T + 40);
    chk("leftover_out", out, 0);
    chk("leftover_strb", n_strb - s0, 0);
    s0 = n_strb;
    send_frame(8'h45, 0);
    chk("resync_out", out, 48);
    chk("resync_strb", n_strb - s0, 1);

    // Random frames against the model
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    m_out = 0; m_ext = 0; m_brk = 0;
    for (int n = 0; n < 40; n++) begin
      c = pool[$urandom_range(15)];
      b = ($urandom_range(7) == 0);
      s0 = n_strb; e0 = n_err;
      model(c, b, es, ee);
      send_frame(c, b);
      chk($sformatf("rnd%0d_out(code %02h)", n, c), out, m_out);
      chk($sformatf("rnd%0d_strb", n), n_strb - s0, es);
      chk($sformatf("rnd%0d_err", n), n_err - e0, ee);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
